// File: rtl/cpu_pkg.sv
// Shared types and constants for the ARMv8 subset CPU: branch opcodes, condition codes,
// the NZVC flag bundle and the fetch FSM state.
package cpu_pkg;

    localparam logic [63:0] PC_RESET_DEFAULT = 64'h0;

    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [5:0]  OP_BL    = 6'b100101;
    localparam logic [7:0]  OP_BCOND = 8'b0101_0100;
    localparam logic [7:0]  OP_CBZ   = 8'b1011_0100;
    localparam logic [21:0] OP_BR    = 22'b1101011000011111000000;

    typedef enum logic [3:0] {
        CondEq = 4'h0,
        CondNe = 4'h1,
        CondHs = 4'h2,
        CondLo = 4'h3,
        CondMi = 4'h4,
        CondPl = 4'h5,
        CondVs = 4'h6,
        CondVc = 4'h7,
        CondHi = 4'h8,
        CondLs = 4'h9,
        CondGe = 4'hA,
        CondLt = 4'hB,
        CondGt = 4'hC,
        CondLe = 4'hD,
        CondAl = 4'hE,
        CondNv = 4'hF
    } cond_t;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } flags_t;

    typedef enum logic [0:0] {
        StRun  = 1'b0,
        StHalt = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/cond_eval.sv
// Evaluates an ARMv8 condition code against a set of NZVC flags.
module cond_eval
    import cpu_pkg::*;
(
    input  cond_t  cond,
    input  flags_t flags,
    output logic   cond_true
);

    logic gt;

    always_comb begin
        cond_true = 1'b0;
        gt        = !flags.z && (flags.n == flags.v);
        unique case (cond)
            CondEq: cond_true = flags.z;
            CondNe: cond_true = !flags.z;
            CondHs: cond_true = flags.c;
            CondLo: cond_true = !flags.c;
            CondMi: cond_true = flags.n;
            CondPl: cond_true = !flags.n;
            CondVs: cond_true = flags.v;
            CondVc: cond_true = !flags.v;
            CondHi: cond_true = flags.c && !flags.z;
            CondLs: cond_true = !(flags.c && !flags.z);
            CondGe: cond_true = (flags.n == flags.v);
            CondLt: cond_true = (flags.n != flags.v);
            CondGt: cond_true = gt;
            CondLe: cond_true = !gt;
            CondAl: cond_true = 1'b1;
            CondNv: cond_true = 1'b1;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, flag register and next-PC selection with a RUN/HALT fetch FSM.
// Define PC_FETCH_BR_EN to decode BR (register-indirect branch).
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [63:0] PC_RESET = PC_RESET_DEFAULT,
    parameter logic [31:0] HLT_WORD = 32'hD440_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        set_flags,
    input  logic        flag_neg,
    input  logic        flag_zero,
    input  logic        flag_overf,
    input  logic        flag_cOut,
    input  logic [63:0] reg_b_data,
    output logic [63:0] pc,
    output logic [63:0] pc_plus_four,
    output logic [3:0]  flags_q,
    output logic        branch_taken,
    output logic        halted
);

    logic [63:0]  pc_q, pc_d;
    flags_t       flags_reg_q, flags_reg_d;
    fetch_state_e state_q, state_d;

    logic         is_b, is_bl, is_bcond, is_cbz, is_br, is_hlt;
    logic [63:0]  off26, off19;
    logic         jump, cond_true;
    logic [63:0]  jump_target;
    cond_t        cond;

    assign is_b     = instruction[31:26] == OP_B;
    assign is_bl    = instruction[31:26] == OP_BL;
    assign is_bcond = (instruction[31:24] == OP_BCOND) && !instruction[4];
    assign is_cbz   = instruction[31:24] == OP_CBZ;
    assign is_hlt   = instruction == HLT_WORD;

`ifdef PC_FETCH_BR_EN
    assign is_br = (instruction[31:10] == OP_BR) && (instruction[4:0] == 5'd0);
`else
    logic unused_reg_b;
    assign is_br        = 1'b0;
    assign unused_reg_b = ^reg_b_data;
`endif

    // Offsets are relative to the branch itself, not pc+4.
    assign off26 = {{36{instruction[25]}}, instruction[25:0], 2'b00};
    assign off19 = {{43{instruction[23]}}, instruction[23:5], 2'b00};
    assign cond  = cond_t'(instruction[3:0]);

    cond_eval u_cond_eval (
        .cond      (cond),
        .flags     (flags_reg_q),
        .cond_true (cond_true)
    );

    always_comb begin
        jump        = 1'b0;
        jump_target = pc_q + off26;
        if (is_b || is_bl) begin
            jump = 1'b1;
        end else if (is_bcond) begin
            jump        = cond_true;
            jump_target = pc_q + off19;
        end else if (is_cbz) begin
            jump        = flag_zero;
            jump_target = pc_q + off19;
        end else if (is_br) begin
            jump        = 1'b1;
            jump_target = reg_b_data;
        end
    end

    always_comb begin
        pc_d        = pc_q;
        flags_reg_d = flags_reg_q;
        state_d     = state_q;
        if (state_q == StRun) begin
            if (is_hlt) begin
                state_d = StHalt;
            end else begin
                pc_d = jump ? jump_target : pc_plus_four;
            end
            if (set_flags) begin
                flags_reg_d = '{n: flag_neg, z: flag_zero, v: flag_overf, c: flag_cOut};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= PC_RESET;
            flags_reg_q <= '0;
            state_q     <= StRun;
        end else begin
            pc_q        <= pc_d;
            flags_reg_q <= flags_reg_d;
            state_q     <= state_d;
        end
    end

    assign pc           = pc_q;
    assign pc_plus_four = pc_q + 64'd4;
    assign flags_q      = flags_reg_q;
    assign branch_taken = jump && (state_q == StRun) && !is_hlt;
    assign halted       = state_q == StHalt;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: expected next-PC values are queued when a step is driven
// and popped after the clock edge.
module tb_pc_fetch_unit;

    localparam logic [31:0] NOP  = 32'hD503_201F;
    localparam logic [31:0] SUBS = 32'hEB01_001F;
    localparam logic [31:0] HLT  = 32'hD440_0000;
    localparam logic [31:0] BR1  = 32'hD61F_0020;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        set_flags;
    logic        flag_neg, flag_zero, flag_overf, flag_cOut;
    logic [63:0] reg_b_data;
    logic [63:0] pc, pc_plus_four;
    logic [3:0]  flags_q;
    logic        branch_taken, halted;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] model_pc;

    pc_fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .instruction  (instruction),
        .set_flags    (set_flags),
        .flag_neg     (flag_neg),
        .flag_zero    (flag_zero),
        .flag_overf   (flag_overf),
        .flag_cOut    (flag_cOut),
        .reg_b_data   (reg_b_data),
        .pc           (pc),
        .pc_plus_four (pc_plus_four),
        .flags_q      (flags_q),
        .branch_taken (branch_taken),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] b_word(input logic [63:0] from, input logic [63:0] to);
        logic [63:0] d;
        d = to - from;
        return {6'b000101, d[27:2]};
    endfunction

    function automatic logic [31:0] bcond_word(input logic [3:0] c, input logic [18:0] imm);
        return {8'h54, imm, 1'b0, c};
    endfunction

    function automatic logic [31:0] cbz_word(input logic [18:0] imm);
        return {8'hB4, imm, 5'd0};
    endfunction

    // Drive one instruction, check combinational outputs, then check pc after the edge.
    task automatic step(input string tag, input logic [31:0] ins, input logic sf,
                        input logic [3:0] fl, input logic [63:0] rb, input logic rst,
                        input logic [63:0] exp_next, input logic exp_taken);
        logic [63:0] want;
        instruction = ins;
        set_flags   = sf;
        {flag_neg, flag_zero, flag_overf, flag_cOut} = fl;
        reg_b_data  = rb;
        reset       = rst;
        #1;
        chk({tag, ".pc4"}, pc_plus_four, model_pc + 64'd4);
        chk({tag, ".taken"}, {63'd0, branch_taken}, {63'd0, exp_taken});
        exp_q.push_back(exp_next);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, ".queue"}, 64'd0, 64'd1);
        end else begin
            want = exp_q.pop_front();
            chk({tag, ".pc"}, pc, want);
            model_pc = want;
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; instruction = NOP; set_flags = 1'b0; reg_b_data = '0;
        {flag_neg, flag_zero, flag_overf, flag_cOut} = 4'b0000;
        @(posedge clk);
        #1;
        model_pc = 64'h0;
        chk("rst.pc", pc, 64'h0);
        chk("rst.pc4", pc_plus_four, 64'h4);
        chk("rst.flags", {60'd0, flags_q}, 64'h0);
        chk("rst.halted", {63'd0, halted}, 64'h0);
        reset = 1'b0;

        step("seq0", NOP, 1'b0, 4'h0, 64'h0, 1'b0, 64'h4, 1'b0);
        step("seq1", NOP, 1'b0, 4'h0, 64'h0, 1'b0, 64'h8, 1'b0);
        step("seq2", NOP, 1'b0, 4'h0, 64'h0, 1'b0, 64'hC, 1'b0);
        step("jmp20", b_word(64'hC, 64'h20), 1'b0, 4'h0, 64'h0, 1'b0, 64'h20, 1'b1);
        step("bneg", b_word(64'h20, 64'h18), 1'b0, 4'h0, 64'h0, 1'b0, 64'h18, 1'b1);
        step("back20", b_word(64'h18, 64'h20), 1'b0, 4'h0, 64'h0, 1'b0, 64'h20, 1'b1);
        step("brst", b_word(64'h20, 64'h18), 1'b0, 4'h0, 64'h0, 1'b1, 64'h0, 1'b1);

        // Flags N=1 V=0 (C=1) registered, B.LT taken.
        step("jmp100", b_word(64'h0, 64'h100), 1'b0, 4'h0, 64'h0, 1'b0, 64'h100, 1'b1);
        step("subs1", SUBS, 1'b1, 4'b1001, 64'h0, 1'b0, 64'h104, 1'b0);
        chk("flags1", {60'd0, flags_q}, 64'h9);
        // Live flags here would make LT false; B.cond must use the registered copy.
        step("blt", bcond_word(4'hB, 19'd4), 1'b1, 4'b0000, 64'h0, 1'b0, 64'h114, 1'b1);
        chk("flags2", {60'd0, flags_q}, 64'h0);
        step("jmp100b", b_word(64'h114, 64'h100), 1'b0, 4'h0, 64'h0, 1'b0, 64'h100, 1'b1);
        step("subs2", SUBS, 1'b1, 4'b1001, 64'h0, 1'b0, 64'h104, 1'b0);
        step("bge", bcond_word(4'hA, 19'd4), 1'b0, 4'b0000, 64'h0, 1'b0, 64'h108, 1'b0);

        step("jmp40", b_word(64'h108, 64'h40), 1'b0, 4'h0, 64'h0, 1'b0, 64'h40, 1'b1);
        step("cbz1", cbz_word(19'd3), 1'b0, 4'b0100, 64'h0, 1'b0, 64'h4C, 1'b1);
        step("jmp40b", b_word(64'h4C, 64'h40), 1'b0, 4'h0, 64'h0, 1'b0, 64'h40, 1'b1);
        step("cbz0", cbz_word(19'd3), 1'b0, 4'b0000, 64'h0, 1'b0, 64'h44, 1'b0);

`ifdef PC_FETCH_BR_EN
        step("br", BR1, 1'b0, 4'h0, 64'h1000, 1'b0, 64'h1000, 1'b1);
`else
        step("br", BR1, 1'b0, 4'h0, 64'h1000, 1'b0, 64'h48, 1'b0);
`endif

        step("jmp30", b_word(model_pc, 64'h30), 1'b0, 4'h0, 64'h0, 1'b0, 64'h30, 1'b1);
        step("hlt", HLT, 1'b0, 4'h0, 64'h0, 1'b0, 64'h30, 1'b0);
        chk("halted", {63'd0, halted}, 64'h1);
        for (int i = 0; i < 5; i++) begin
            step("hold", b_word(64'h30, 64'h80), 1'b1, 4'b0110, 64'h0, 1'b0, 64'h30, 1'b0);
        end
        chk("hold.flags", {60'd0, flags_q}, 64'h9);
        chk("hold.halted", {63'd0, halted}, 64'h1);
        step("hrst", NOP, 1'b0, 4'h0, 64'h0, 1'b1, 64'h0, 1'b0);
        chk("hrst.halted", {63'd0, halted}, 64'h0);
        chk("hrst.flags", {60'd0, flags_q}, 64'h0);

        // Wrap through the top of the address space.
        step("wrapneg", b_word(64'h0, 64'hFFFF_FFFF_FFFF_FFFC), 1'b0, 4'h0, 64'h0, 1'b0,
             64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
        step("wrap0", NOP, 1'b0, 4'h0, 64'h0, 1'b0, 64'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
